// File: rtl/sprite_renderer_if.sv
// Sprite position bus carrying the ball centre and radius from the motion logic
// to the renderer, once per frame.
interface sprite_renderer_if;
   logic [9:0] BallX;
   logic [9:0] BallY;
   logic [9:0] BallS;

   modport master (output BallX, BallY, BallS);
   modport slave  (input  BallX, BallY, BallS);
endinterface

// File: rtl/sprite_renderer.sv
// Renders a filled disc onto the VGA pixel stream through a 3-stage pipeline
// and reports the lit-pixel count of each completed frame.
module sprite_renderer #(
   parameter logic [23:0] BALL_RGB = 24'hFF5500,
   parameter logic [23:0] BG_RGB   = 24'h000040
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             frame_start,
   input  logic             pix_valid,
   input  logic [9:0]       DrawX,
   input  logic [9:0]       DrawY,
   sprite_renderer_if.slave ball,
   output logic [7:0]       Red,
   output logic [7:0]       Green,
   output logic [7:0]       Blue,
   output logic             pix_out_valid,
   output logic [18:0]      frame_lit
);
   localparam logic [18:0] CNT_MAX = 19'h7FFFF;

   logic [9:0]  lx_q, lx_d, ly_q, ly_d, ls_q, ls_d;
   logic        v1_q, v1_d;
   logic [10:0] dx_q, dx_d, dy_q, dy_d;
   logic [9:0]  ls1_q, ls1_d;
   logic        v2_q, v2_d;
   logic [21:0] d2_q, d2_d, r2_q, r2_d;
   logic        v3_q, v3_d;
   logic [23:0] rgb_q, rgb_d;
   logic [18:0] cnt_q, cnt_d, frame_lit_q, frame_lit_d;
   logic [10:0] dx_abs, dy_abs;
   logic [21:0] dx_w, dy_w, ls_w;
   logic [18:0] cnt_inc;
   logic        hit;

   // Geometry is frozen per frame; the pixel entering stage 1 this cycle still sees the old latch
   always_comb begin
      lx_d = lx_q;
      ly_d = ly_q;
      ls_d = ls_q;
      if (frame_start) begin
         lx_d = ball.BallX;
         ly_d = ball.BallY;
         ls_d = ball.BallS;
      end
   end

   always_comb begin
      v1_d  = pix_valid;
      dx_d  = dx_q;
      dy_d  = dy_q;
      ls1_d = ls1_q;
      if (pix_valid) begin
         dx_d  = {1'b0, DrawX} - {1'b0, lx_q};
         dy_d  = {1'b0, DrawY} - {1'b0, ly_q};
         ls1_d = ls_q;
      end
   end

   // Squaring the magnitude avoids signed multiply; |dx| never exceeds 1023
   always_comb begin
      dx_abs = dx_q[10] ? (~dx_q + 11'd1) : dx_q;
      dy_abs = dy_q[10] ? (~dy_q + 11'd1) : dy_q;
      dx_w   = {11'd0, dx_abs};
      dy_w   = {11'd0, dy_abs};
      ls_w   = {12'd0, ls1_q};
      v2_d   = v1_q;
      d2_d   = dx_w * dx_w + dy_w * dy_w;
      r2_d   = ls_w * ls_w;
   end

   always_comb begin
      hit   = (d2_q <= r2_q);
      v3_d  = v2_q;
      rgb_d = v2_q ? (hit ? BALL_RGB : BG_RGB) : 24'd0;
   end

   // The hit landing on the frame_start edge still belongs to the frame being closed
   always_comb begin
      cnt_inc = cnt_q;
      if (v2_q && hit && (cnt_q != CNT_MAX)) begin
         cnt_inc = cnt_q + 19'd1;
      end
      cnt_d       = cnt_inc;
      frame_lit_d = frame_lit_q;
      if (frame_start) begin
         frame_lit_d = cnt_inc;
         cnt_d       = '0;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         lx_q        <= '0;
         ly_q        <= '0;
         ls_q        <= '0;
         v1_q        <= 1'b0;
         dx_q        <= '0;
         dy_q        <= '0;
         ls1_q       <= '0;
         v2_q        <= 1'b0;
         d2_q        <= '0;
         r2_q        <= '0;
         v3_q        <= 1'b0;
         rgb_q       <= '0;
         cnt_q       <= '0;
         frame_lit_q <= '0;
      end else begin
         lx_q        <= lx_d;
         ly_q        <= ly_d;
         ls_q        <= ls_d;
         v1_q        <= v1_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         ls1_q       <= ls1_d;
         v2_q        <= v2_d;
         d2_q        <= d2_d;
         r2_q        <= r2_d;
         v3_q        <= v3_d;
         rgb_q       <= rgb_d;
         cnt_q       <= cnt_d;
         frame_lit_q <= frame_lit_d;
      end
   end

   assign Red           = rgb_q[23:16];
   assign Green         = rgb_q[15:8];
   assign Blue          = rgb_q[7:0];
   assign pix_out_valid = v3_q;
   assign frame_lit     = frame_lit_q;
endmodule

// File: tb/tb_sprite_renderer.sv
// Self-checking bench for sprite_renderer: randomized pixel streams compared
// against an integer disc model, plus directed boundary scenarios.
module tb_sprite_renderer;
   localparam logic [23:0] BALL = 24'hFF5500;
   localparam logic [23:0] BG   = 24'h000040;
   localparam int MAXN = 20000;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        frame_start = 1'b0;
   logic        pix_valid = 1'b0;
   logic [9:0]  DrawX = '0;
   logic [9:0]  DrawY = '0;
   logic [7:0]  Red, Green, Blue;
   logic        pix_out_valid;
   logic [18:0] frame_lit;

   sprite_renderer_if bif ();

   sprite_renderer dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .frame_start  (frame_start),
      .pix_valid    (pix_valid),
      .DrawX        (DrawX),
      .DrawY        (DrawY),
      .ball         (bif.slave),
      .Red          (Red),
      .Green        (Green),
      .Blue         (Blue),
      .pix_out_valid(pix_out_valid),
      .frame_lit    (frame_lit)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   int n = 0;

   // Expected and observed values, indexed by cycle number
   bit          exp_v   [MAXN];
   bit          exp_hit [MAXN];
   logic [23:0] exp_rgb [MAXN];
   int          exp_fl  [MAXN];
   logic        obs_v   [MAXN];
   logic [23:0] obs_rgb [MAXN];
   logic [18:0] obs_fl  [MAXN];

   int mlx, mly, mls, mcnt, mfl;

   function automatic bit model_hit(int x, int y);
      int ddx, ddy;
      ddx = x - mlx;
      ddy = y - mly;
      return (ddx * ddx + ddy * ddy) <= (mls * mls);
   endfunction

   task automatic set_ball(int x, int y, int s);
      bif.BallX = 10'(x);
      bif.BallY = 10'(y);
      bif.BallS = 10'(s);
   endtask

   task automatic model_reset();
      mlx = 0; mly = 0; mls = 0; mcnt = 0; mfl = 0;
      for (int k = 0; k < 2; k++) begin
         exp_v[n + k]   = 1'b0;
         exp_hit[n + k] = 1'b0;
         exp_rgb[n + k] = '0;
      end
   endtask

   // One pixel-clock cycle: drive inputs, advance the model, sample after the edge
   task automatic step(bit fs, bit pv, int x, int y);
      bit h;
      if (n >= MAXN - 3) begin
         $display("[TB] FAIL cycle_budget: n=%0d, limit=%0d", n, MAXN - 3);
         $fatal(1, "[TB] cycle budget exhausted");
      end
      frame_start = fs;
      pix_valid   = pv;
      DrawX       = 10'(x);
      DrawY       = 10'(y);
      h = pv && model_hit(x, y);
      exp_v[n + 2]   = pv;
      exp_hit[n + 2] = h;
      exp_rgb[n + 2] = pv ? (h ? BALL : BG) : 24'd0;
      if (exp_v[n] && exp_hit[n] && mcnt < 524287) mcnt++;
      if (fs) begin
         mfl  = mcnt;
         mcnt = 0;
         mlx  = int'(bif.BallX);
         mly  = int'(bif.BallY);
         mls  = int'(bif.BallS);
      end
      exp_fl[n] = mfl;
      @(posedge Clk);
      #1;
      obs_v[n]   = pix_out_valid;
      obs_rgb[n] = {Red, Green, Blue};
      obs_fl[n]  = frame_lit;
      n++;
   endtask

   task automatic idle(int cycles);
      for (int k = 0; k < cycles; k++) step(1'b0, 1'b0, $urandom_range(0, 639), $urandom_range(0, 479));
   endtask

   task automatic test_reset();
      int s;
      Reset_n = 1'b0;
      for (int k = 0; k < 5; k++) begin
         pix_valid   = $urandom_range(0, 1);
         frame_start = 1'b0;
         DrawX       = 10'($urandom_range(0, 639));
         DrawY       = 10'($urandom_range(0, 479));
         @(posedge Clk);
         #1;
         checks++;
         if ({pix_out_valid, Red, Green, Blue, frame_lit} !== 44'd0) begin
            errors++;
            $display("[TB] FAIL reset_hold: v=%b rgb=%h lit=%0d, expected all zero", pix_out_valid, {Red, Green, Blue}, frame_lit);
         end
      end
      Reset_n = 1'b1;
      model_reset();
      s = n;
      step(1'b0, 1'b1, $urandom_range(0, 639), $urandom_range(0, 479));
      idle(4);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (obs_v[s + k] !== (k == 2)) begin
            errors++;
            $display("[TB] FAIL reset_latency_c%0d: got v=%b, expected %b", k, obs_v[s + k], (k == 2));
         end
      end
      for (int i = s; i < n; i++) begin
         checks++;
         if (obs_v[i] !== exp_v[i] || obs_rgb[i] !== exp_rgb[i] || obs_fl[i] !== 19'(exp_fl[i])) begin
            errors++;
            $display("[TB] FAIL reset_stream_%0d: got v=%b rgb=%h lit=%0d, expected v=%b rgb=%h lit=%0d",
                     i, obs_v[i], obs_rgb[i], obs_fl[i], exp_v[i], exp_rgb[i], exp_fl[i]);
         end
      end
   endtask

   task automatic test_centre();
      int s;
      set_ball(320, 240, 8);
      s = n;
      step(1'b1, 1'b0, 0, 0);
      step(1'b0, 1'b1, 320, 240);
      step(1'b0, 1'b1, 329, 240);
      step(1'b0, 1'b1, 328, 240);
      idle(3);
      checks++;
      if (obs_v[s + 3] !== 1'b1 || obs_rgb[s + 3] !== 24'hFF5500) begin
         errors++;
         $display("[TB] FAIL centre_hit: got v=%b rgb=%h, expected 1 ff5500", obs_v[s + 3], obs_rgb[s + 3]);
      end
      checks++;
      if (obs_rgb[s + 4] !== 24'h000040) begin
         errors++;
         $display("[TB] FAIL centre_outside: got %h, expected 000040", obs_rgb[s + 4]);
      end
      checks++;
      if (obs_rgb[s + 5] !== 24'hFF5500) begin
         errors++;
         $display("[TB] FAIL centre_boundary: got %h, expected ff5500", obs_rgb[s + 5]);
      end
      for (int i = s; i < n; i++) begin
         checks++;
         if (obs_v[i] !== exp_v[i] || obs_rgb[i] !== exp_rgb[i] || obs_fl[i] !== 19'(exp_fl[i])) begin
            errors++;
            $display("[TB] FAIL centre_stream_%0d: got v=%b rgb=%h lit=%0d, expected v=%b rgb=%h lit=%0d",
                     i, obs_v[i], obs_rgb[i], obs_fl[i], exp_v[i], exp_rgb[i], exp_fl[i]);
         end
      end
   endtask

   task automatic scan_window(int x0, int x1, int y0, int y1);
      for (int y = y0; y <= y1; y++) begin
         for (int x = x0; x <= x1; x++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            step(1'b0, 1'b1, x, y);
         end
      end
   endtask

   task automatic test_frame_count();
      int s;
      set_ball(320, 240, 8);
      s = n;
      step(1'b1, 1'b0, 0, 0);
      scan_window(308, 332, 228, 252);
      idle(2);
      set_ball(320, 240, 0);
      step(1'b1, 1'b0, 0, 0);
      checks++;
      if (obs_fl[n - 1] !== 19'd197) begin
         errors++;
         $display("[TB] FAIL frame_lit_r8: got %0d, expected 197", obs_fl[n - 1]);
      end
      scan_window(308, 332, 228, 252);
      idle(2);
      step(1'b1, 1'b0, 0, 0);
      checks++;
      if (obs_fl[n - 1] !== 19'd1) begin
         errors++;
         $display("[TB] FAIL frame_lit_r0: got %0d, expected 1", obs_fl[n - 1]);
      end
      for (int i = s; i < n; i++) begin
         checks++;
         if (obs_v[i] !== exp_v[i] || obs_rgb[i] !== exp_rgb[i] || obs_fl[i] !== 19'(exp_fl[i])) begin
            errors++;
            $display("[TB] FAIL count_stream_%0d: got v=%b rgb=%h lit=%0d, expected v=%b rgb=%h lit=%0d",
                     i, obs_v[i], obs_rgb[i], obs_fl[i], exp_v[i], exp_rgb[i], exp_fl[i]);
         end
      end
   endtask

   task automatic test_latch_isolation();
      int s, p, q;
      set_ball(320, 240, 8);
      s = n;
      step(1'b1, 1'b0, 0, 0);
      for (int x = 315; x <= 325; x++) step(1'b0, 1'b1, x, 239);
      set_ball(100, 240, 8);
      p = n;
      step(1'b0, 1'b1, 320, 240);
      for (int x = 321; x <= 330; x++) step(1'b0, 1'b1, x, 240);
      idle(2);
      checks++;
      if (obs_rgb[p + 2] !== BALL) begin
         errors++;
         $display("[TB] FAIL latch_hold: got %h, expected %h", obs_rgb[p + 2], BALL);
      end
      step(1'b1, 1'b0, 0, 0);
      q = n;
      step(1'b0, 1'b1, 100, 240);
      step(1'b0, 1'b1, 320, 240);
      idle(2);
      checks++;
      if (obs_rgb[q + 2] !== BALL || obs_rgb[q + 3] !== BG) begin
         errors++;
         $display("[TB] FAIL latch_next_frame: got %h %h, expected %h %h", obs_rgb[q + 2], obs_rgb[q + 3], BALL, BG);
      end
      for (int i = s; i < n; i++) begin
         checks++;
         if (obs_v[i] !== exp_v[i] || obs_rgb[i] !== exp_rgb[i] || obs_fl[i] !== 19'(exp_fl[i])) begin
            errors++;
            $display("[TB] FAIL latch_stream_%0d: got v=%b rgb=%h lit=%0d, expected v=%b rgb=%h lit=%0d",
                     i, obs_v[i], obs_rgb[i], obs_fl[i], exp_v[i], exp_rgb[i], exp_fl[i]);
         end
      end
   endtask

   task automatic test_simultaneous();
      int s, k;
      set_ball(100, 100, 8);
      s = n;
      step(1'b1, 1'b0, 0, 0);
      idle(1);
      set_ball(320, 240, 8);
      k = n;
      step(1'b1, 1'b1, 320, 240);
      step(1'b0, 1'b1, 320, 240);
      idle(2);
      checks++;
      if (obs_rgb[k + 2] !== BG) begin
         errors++;
         $display("[TB] FAIL simul_old_latch: got %h, expected %h", obs_rgb[k + 2], BG);
      end
      checks++;
      if (obs_rgb[k + 3] !== BALL) begin
         errors++;
         $display("[TB] FAIL simul_new_latch: got %h, expected %h", obs_rgb[k + 3], BALL);
      end
      for (int i = s; i < n; i++) begin
         checks++;
         if (obs_v[i] !== exp_v[i] || obs_rgb[i] !== exp_rgb[i] || obs_fl[i] !== 19'(exp_fl[i])) begin
            errors++;
            $display("[TB] FAIL simul_stream_%0d: got v=%b rgb=%h lit=%0d, expected v=%b rgb=%h lit=%0d",
                     i, obs_v[i], obs_rgb[i], obs_fl[i], exp_v[i], exp_rgb[i], exp_fl[i]);
         end
      end
   endtask

   task automatic test_edge();
      int s, on_screen;
      on_screen = 0;
      for (int y = 0; y < 480; y++)
         for (int x = 0; x < 640; x++)
            if ((x - 2) * (x - 2) + (y - 2) * (y - 2) <= 64) on_screen++;
      set_ball(2, 2, 8);
      s = n;
      step(1'b1, 1'b0, 0, 0);
      scan_window(0, 15, 0, 15);
      scan_window(628, 639, 0, 10);
      scan_window(0, 10, 469, 479);
      scan_window(630, 639, 472, 479);
      idle(2);
      step(1'b1, 1'b0, 0, 0);
      checks++;
      if (obs_fl[n - 1] !== 19'(on_screen)) begin
         errors++;
         $display("[TB] FAIL edge_frame_lit: got %0d, expected %0d", obs_fl[n - 1], on_screen);
      end
      for (int i = s; i < n; i++) begin
         checks++;
         if (obs_v[i] !== exp_v[i] || obs_rgb[i] !== exp_rgb[i] || obs_fl[i] !== 19'(exp_fl[i])) begin
            errors++;
            $display("[TB] FAIL edge_stream_%0d: got v=%b rgb=%h lit=%0d, expected v=%b rgb=%h lit=%0d",
                     i, obs_v[i], obs_rgb[i], obs_fl[i], exp_v[i], exp_rgb[i], exp_fl[i]);
         end
      end
   endtask

   task automatic test_random();
      int s, bx, by, x, y;
      s = n;
      for (int f = 0; f < 5; f++) begin
         bx = $urandom_range(0, 1023);
         by = $urandom_range(0, 1023);
         if ($urandom_range(0, 2) != 0) begin
            bx = $urandom_range(0, 700);
            by = $urandom_range(0, 520);
         end
         set_ball(bx, by, $urandom_range(0, 60));
         step(1'b1, ($urandom_range(0, 1) == 1), $urandom_range(0, 639), $urandom_range(0, 479));
         for (int k = 0; k < 500; k++) begin
            x = bx + $urandom_range(0, 140) - 70;
            y = by + $urandom_range(0, 140) - 70;
            if ($urandom_range(0, 4) == 0) begin
               x = $urandom_range(0, 639);
               y = $urandom_range(0, 479);
            end
            x = (x < 0) ? 0 : ((x > 639) ? 639 : x);
            y = (y < 0) ? 0 : ((y > 479) ? 479 : y);
            step(1'b0, ($urandom_range(0, 3) != 0), x, y);
         end
      end
      idle(2);
      step(1'b1, 1'b0, 0, 0);
      for (int i = s; i < n; i++) begin
         checks++;
         if (obs_v[i] !== exp_v[i] || obs_rgb[i] !== exp_rgb[i] || obs_fl[i] !== 19'(exp_fl[i])) begin
            errors++;
            $display("[TB] FAIL random_stream_%0d: got v=%b rgb=%h lit=%0d, expected v=%b rgb=%h lit=%0d",
                     i, obs_v[i], obs_rgb[i], obs_fl[i], exp_v[i], exp_rgb[i], exp_fl[i]);
         end
      end
   endtask

   task automatic test_reset_midframe();
      int s;
      set_ball(320, 240, 8);
      step(1'b1, 1'b0, 0, 0);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 320, 240);
      Reset_n = 1'b0;
      #2;
      checks++;
      if ({pix_out_valid, Red, Green, Blue, frame_lit} !== 44'd0) begin
         errors++;
         $display("[TB] FAIL midreset_async: v=%b rgb=%h lit=%0d, expected all zero", pix_out_valid, {Red, Green, Blue}, frame_lit);
      end
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      model_reset();
      s = n;
      step(1'b0, 1'b0, 0, 0);
      step(1'b1, 1'b0, 0, 0);
      checks++;
      if (obs_fl[n - 1] !== 19'd0 || obs_v[s] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_count_lost: got lit=%0d v=%b, expected 0 0", obs_fl[n - 1], obs_v[s]);
      end
      step(1'b0, 1'b1, 320, 240);
      idle(3);
      for (int i = s; i < n; i++) begin
         checks++;
         if (obs_v[i] !== exp_v[i] || obs_rgb[i] !== exp_rgb[i] || obs_fl[i] !== 19'(exp_fl[i])) begin
            errors++;
            $display("[TB] FAIL midreset_stream_%0d: got v=%b rgb=%h lit=%0d, expected v=%b rgb=%h lit=%0d",
                     i, obs_v[i], obs_rgb[i], obs_fl[i], exp_v[i], exp_rgb[i], exp_fl[i]);
         end
      end
   endtask

   initial begin
      set_ball(0, 0, 0);
      test_reset();
      test_centre();
      test_frame_count();
      test_latch_isolation();
      test_simultaneous();
      test_edge();
      test_random();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
